regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Single-writer front end for the 32×32 register file: merges the in-order pipeline writeback stream and the out-of-band long-latency result stream (loads from slow memory, mul/div) onto the register file's one write port. Long-latency results are buffered in a small queue, drained when the pipeline writeback slot is idle, and guarded against write-after-write reordering. Sits between the WB stage / long-latency unit and `register_file` (`reg_write`, `write_addr`, `write_data`).

## Interface
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register address width
- `DEPTH`, 4, queue entries (power of 2, ≥2)
- `MAX_WAIT`, 8, cycles a valid queue head may be bypassed before `wb_stall` asserts
- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `wb_valid` in 1 — pipeline writeback request; no backpressure; always takes priority
- `wb_addr` in ADDR_W — pipeline destination register
- `wb_data` in DATA_W — pipeline result
- `lt_valid` in 1 — long-latency result offered
- `lt_ready` out 1 — queue can accept; transfer on `lt_valid && lt_ready` at rising edge
- `lt_addr` in ADDR_W — long-latency destination
- `lt_data` in DATA_W — long-latency result
- `rf_reg_write` out 1 — to register file `reg_write`, registered
- `rf_write_addr` out ADDR_W — to `write_addr`, registered
- `rf_write_data` out DATA_W — to `write_data`, registered
- `wb_stall` out 1 — registered; upstream holds `wb_valid`=0 on every cycle it is high
- `query_addr` in ADDR_W — hazard probe from decode
- `query_pending` out 1 — combinational: a live queue entry targets `query_addr`
- `q_count` out $clog2(DEPTH)+1 — occupancy (live and killed entries)

## Operation
- Reset (`rst_n`=0, async): `rf_reg_write`=0, `rf_write_addr`=0, `rf_write_data`=0, `wb_stall`=0, queue empty, `q_count`=0, wait counter 0; `lt_ready`=1, `query_pending`=0.
- Per edge, issue priority: (1) `wb_valid` with `wb_addr`≠0 → drive rf outputs from wb; (2) otherwise, queue non-empty → pop head; live head drives rf outputs, killed head pops with `rf_reg_write`=0; (3) otherwise `rf_reg_write`=0 (addr/data hold last value).
- `wb_valid` with `wb_addr`=0: no rf write, but slot counts as used (queue does not drain that cycle).
- Accept: `lt_ready` = `q_count`<DEPTH (no same-cycle pop credit). Accepted entries with `lt_addr`=0 are dropped, not enqueued.
- WAW kill: issued wb write to X clears the live bit of every queued entry targeting X. An entry enqueued on the same edge is younger and survives.
- Simultaneous enqueue and pop: both happen; `q_count` unchanged.
- `query_pending` ignores `query_addr`=0 and killed entries; includes no in-flight rf output.
- Starvation: wait counter increments each edge the queue is non-empty and `wb_valid`=1; clears on any pop or empty queue. When it reaches MAX_WAIT, `wb_stall`=1 next cycle; head pops on that cycle; `wb_stall` clears the edge after the pop. `wb_valid`=1 while `wb_stall`=1 is a protocol violation (wb still wins; counter saturates).

## Timing
- wb→rf: 1 cycle (wb sampled at edge N, rf outputs valid after N, written into register file at N+1).
- lt→rf: ≥2 cycles (enqueue at N, earliest pop at N+1, register-file write at N+2).
- Queue full: `lt_ready`=0 until the edge after a pop.
- `wb_stall` rises the edge after the counter hits MAX_WAIT, high exactly one cycle per forced pop.
- Reset asserted mid-drain: queue contents discarded immediately; no partial write.

## Structure
- Package `regfile_pkg`: `DATA_W`, `ADDR_W`, `REG_ZERO`=5'd0, queue entry typedef {live, addr, data}.
- Sub-module `regfile_wb_queue`: circular FIFO with per-entry live bits, broadcast-kill-by-address port, and address-match probe; arbiter and starvation counter stay in the top.

## Test plan
- Reset: hold `rst_n`=0 two cycles → all rf outputs 0, `lt_ready`=1, `q_count`=0; reset released, `wb_valid`=1 reg 5 0xDEADBEEF → `rf_reg_write`=1, addr 5, data 0xDEADBEEF one cycle later.
- Queue drain: lt writes reg 10 0xCAFECAFE and reg 11 0x1 with `wb_valid`=0 → rf writes appear in order at +2 and +3 cycles; `q_count` returns to 0.
- Full/backpressure: `wb_valid` held 1 (regs 1..4), push 4 lt entries → `lt_ready`=0 on 5th offer; after first pop, accept resumes.
- WAW kill: lt reg 12 = 100 queued, then wb reg 12 = 999 → `query_pending`(12) drops to 0, rf sees only 999, killed entry pops with `rf_reg_write`=0.
- Zero register: wb and lt to reg 0 with 0x12345678 → no `rf_reg_write`, `q_count` unchanged.
- Starvation: one lt entry queued, `wb_valid`=1 continuously → `wb_stall`=1 after MAX_WAIT=8 cycles; upstream drops `wb_valid`, entry issues, `wb_stall` clears next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and queue entry layout for the register-file write front end.
// Constant definitions only; no timing.
// No flow control here.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } q_entry_t;

endpackage

// File: rtl/regfile_wb_queue.sv
// Circular queue of long-latency results with per-entry live bits, address kill and address probe.
// Latency: push visible at head one edge later; probe is combinational.
// Backpressure: caller must not push when full or pop when empty.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_vld,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_vld,
    output q_entry_t          head_dat,
    output logic [CNT_W-1:0]  count,
    input  logic              kill_vld,
    input  logic [ADDR_W-1:0] kill_addr,
    input  logic [ADDR_W-1:0] query_addr,
    output logic              query_pending
);

    localparam int PTR_W = $clog2(DEPTH);

    q_entry_t          mem_q [DEPTH];
    q_entry_t          mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  probe_idx;

    always_comb begin
        mem_d = mem_q;
        // Kill sees only entries already stored; a same-edge push lands live afterwards.
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_vld && mem_q[i].addr == kill_addr) begin
                mem_d[i].live = 1'b0;
            end
        end
        if (push_vld) begin
            mem_d[wr_ptr_q] = '{live: 1'b1, addr: push_addr, data: push_data};
        end
        wr_ptr_d = push_vld ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_vld ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_vld) - CNT_W'(pop_vld);
    end

    always_comb begin
        query_pending = 1'b0;
        probe_idx     = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            probe_idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q && mem_q[probe_idx].live &&
                mem_q[probe_idx].addr == query_addr && query_addr != REG_ZERO) begin
                query_pending = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges pipeline writeback and queued long-latency results onto the single register-file write port.
// Latency: wb->rf 1 cycle, lt->rf at least 2 cycles; outputs registered.
// Backpressure: lt_ready drops when the queue is full; wb_stall forces a pop after MAX_WAIT bypasses.
module regfile_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     lt_valid,
    output logic                     lt_ready,
    input  logic [ADDR_W-1:0]        lt_addr,
    input  logic [DATA_W-1:0]        lt_data,
    output logic                     rf_reg_write,
    output logic [ADDR_W-1:0]        rf_write_addr,
    output logic [DATA_W-1:0]        rf_write_data,
    output logic                     wb_stall,
    input  logic [ADDR_W-1:0]        query_addr,
    output logic                     query_pending,
    output logic [$clog2(DEPTH):0]   q_count
);

    import regfile_pkg::*;

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    q_entry_t            q_head;
    logic                q_empty;
    logic                lt_push;
    logic                wb_issue;
    logic                q_pop;

    logic                rf_reg_write_q, rf_reg_write_d;
    logic [ADDR_W-1:0]   rf_write_addr_q, rf_write_addr_d;
    logic [DATA_W-1:0]   rf_write_data_q, rf_write_data_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                wb_stall_q, wb_stall_d;

    assign q_empty  = (q_count == '0);
    assign lt_ready = (q_count < CNT_W'(DEPTH));
    assign lt_push  = lt_valid && lt_ready && (lt_addr != REG_ZERO);
    assign wb_issue = wb_valid && (wb_addr != REG_ZERO);
    // A wb to r0 still occupies the slot, so the queue only drains when wb_valid is low.
    assign q_pop    = !wb_valid && !q_empty;

    regfile_wb_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_vld      (lt_push),
        .push_addr     (lt_addr),
        .push_data     (lt_data),
        .pop_vld       (q_pop),
        .head_dat      (q_head),
        .count         (q_count),
        .kill_vld      (wb_issue),
        .kill_addr     (wb_addr),
        .query_addr    (query_addr),
        .query_pending (query_pending)
    );

    always_comb begin
        rf_reg_write_d  = 1'b0;
        rf_write_addr_d = rf_write_addr_q;
        rf_write_data_d = rf_write_data_q;
        if (wb_issue) begin
            rf_reg_write_d  = 1'b1;
            rf_write_addr_d = wb_addr;
            rf_write_data_d = wb_data;
        end else if (q_pop && q_head.live) begin
            rf_reg_write_d  = 1'b1;
            rf_write_addr_d = q_head.addr;
            rf_write_data_d = q_head.data;
        end

        // Counts edges the head was bypassed by wb; saturates if upstream ignores the stall.
        wait_d = wait_q;
        if (q_empty || q_pop) begin
            wait_d = '0;
        end else if (wb_valid && wait_q != WAIT_W'(MAX_WAIT)) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        wb_stall_d = !q_empty && !q_pop && (wait_q == WAIT_W'(MAX_WAIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_reg_write_q  <= 1'b0;
            rf_write_addr_q <= '0;
            rf_write_data_q <= '0;
            wait_q          <= '0;
            wb_stall_q      <= 1'b0;
        end else begin
            rf_reg_write_q  <= rf_reg_write_d;
            rf_write_addr_q <= rf_write_addr_d;
            rf_write_data_q <= rf_write_data_d;
            wait_q          <= wait_d;
            wb_stall_q      <= wb_stall_d;
        end
    end

    assign rf_reg_write  = rf_reg_write_q;
    assign rf_write_addr = rf_write_addr_q;
    assign rf_write_data = rf_write_data_q;
    assign wb_stall      = wb_stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a queue-based reference model checked every cycle.
module tb_regfile_write_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        lt_valid = 1'b0;
    logic        lt_ready;
    logic [4:0]  lt_addr = '0;
    logic [31:0] lt_data = '0;
    logic        rf_reg_write;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        wb_stall;
    logic [4:0]  query_addr = '0;
    logic        query_pending;
    logic [2:0]  q_count;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_write_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .lt_valid      (lt_valid),
        .lt_ready      (lt_ready),
        .lt_addr       (lt_addr),
        .lt_data       (lt_data),
        .rf_reg_write  (rf_reg_write),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .wb_stall      (wb_stall),
        .query_addr    (query_addr),
        .query_pending (query_pending),
        .q_count       (q_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ordered list of pending results plus the architectural rf output.
    typedef struct {
        bit          live;
        logic [4:0]  addr;
        logic [31:0] data;
    } m_ent_t;

    m_ent_t      mq[$];
    bit          m_wr    = 1'b0;
    logic [4:0]  m_addr  = '0;
    logic [31:0] m_data  = '0;
    bit          m_stall = 1'b0;
    int          m_wait  = 0;

    function automatic bit model_pending(input logic [4:0] a);
        bit hit = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].live && mq[i].addr == a && a != 5'd0) hit = 1'b1;
        end
        return hit;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_wr = 1'b0; m_addr = '0; m_data = '0; m_stall = 1'b0; m_wait = 0;
        end else begin
            bit     can_take;
            bit     wb_wins;
            bit     drains;
            m_ent_t ne;
            can_take = mq.size() < DEPTH;
            wb_wins  = wb_valid && wb_addr != 5'd0;
            drains   = !wb_valid && mq.size() > 0;
            m_wr = 1'b0;
            if (wb_wins) begin
                m_wr = 1'b1; m_addr = wb_addr; m_data = wb_data;
            end else if (drains && mq[0].live) begin
                m_wr = 1'b1; m_addr = mq[0].addr; m_data = mq[0].data;
            end
            m_stall = (mq.size() > 0) && !drains && (m_wait == MAX_WAIT);
            if (mq.size() == 0 || drains) m_wait = 0;
            else if (wb_valid && m_wait < MAX_WAIT) m_wait++;
            if (wb_wins) begin
                foreach (mq[i]) if (mq[i].addr == wb_addr) mq[i].live = 1'b0;
            end
            if (drains) void'(mq.pop_front());
            if (lt_valid && can_take && lt_addr != 5'd0) begin
                ne.live = 1'b1; ne.addr = lt_addr; ne.data = lt_data;
                mq.push_back(ne);
            end
        end
    end

    always @(posedge clk) begin
        #2;
        check("m_rf_reg_write", 64'(rf_reg_write), 64'(m_wr));
        check("m_rf_write_addr", 64'(rf_write_addr), 64'(m_addr));
        check("m_rf_write_data", 64'(rf_write_data), 64'(m_data));
        check("m_wb_stall", 64'(wb_stall), 64'(m_stall));
        check("m_q_count", 64'(q_count), 64'(mq.size()));
        check("m_lt_ready", 64'(lt_ready), 64'(mq.size() < DEPTH));
        check("m_query_pending", 64'(query_pending), 64'(model_pending(query_addr)));
    end

    task automatic step(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic [4:0] qa);
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        lt_valid = lv; lt_addr = la; lt_data = ld;
        query_addr = qa;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_reg_write", 64'(rf_reg_write), 64'(0));
        check("rst_addr", 64'(rf_write_addr), 64'(0));
        check("rst_data", 64'(rf_write_data), 64'(0));
        check("rst_lt_ready", 64'(lt_ready), 64'(1));
        check("rst_q_count", 64'(q_count), 64'(0));
        check("rst_stall", 64'(wb_stall), 64'(0));
        rst_n = 1'b1;

        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        check("wb_write", 64'(rf_reg_write), 64'(1));
        check("wb_addr", 64'(rf_write_addr), 64'(5));
        check("wb_data", 64'(rf_write_data), 64'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 0);
        check("idle_no_write", 64'(rf_reg_write), 64'(0));
        check("idle_addr_hold", 64'(rf_write_addr), 64'(5));

        // In-order drain of two long-latency results
        step(0, 0, 0, 1, 10, 32'hCAFECAFE, 0);
        check("drain_cnt1", 64'(q_count), 64'(1));
        check("drain_nowrite", 64'(rf_reg_write), 64'(0));
        step(0, 0, 0, 1, 11, 32'h1, 0);
        check("drain_w10", 64'(rf_reg_write), 64'(1));
        check("drain_a10", 64'(rf_write_addr), 64'(10));
        check("drain_d10", 64'(rf_write_data), 64'hCAFECAFE);
        step(0, 0, 0, 0, 0, 0, 0);
        check("drain_a11", 64'(rf_write_addr), 64'(11));
        check("drain_d11", 64'(rf_write_data), 64'(1));
        check("drain_empty", 64'(q_count), 64'(0));
        step(0, 0, 0, 0, 0, 0, 0);

        // Fill the queue while wb occupies every slot
        for (int k = 0; k < 4; k++) begin
            step(1, 5'(k + 1), 32'h100 + 32'(k), 1, 5'(20 + k), 32'h200 + 32'(k), 0);
        end
        check("full_cnt", 64'(q_count), 64'(4));
        check("full_rdy", 64'(lt_ready), 64'(0));
        check("full_wb_data", 64'(rf_write_data), 64'h103);
        step(1, 1, 32'h111, 1, 24, 32'h224, 0);
        check("full_reject", 64'(q_count), 64'(4));
        step(0, 0, 0, 1, 24, 32'h224, 0);
        check("full_pop_a", 64'(rf_write_addr), 64'(20));
        check("full_pop_d", 64'(rf_write_data), 64'h200);
        check("full_cnt3", 64'(q_count), 64'(3));
        check("full_rdy_back", 64'(lt_ready), 64'(1));
        step(0, 0, 0, 1, 24, 32'h224, 0);
        check("full_push_pop", 64'(q_count), 64'(3));
        check("full_a21", 64'(rf_write_addr), 64'(21));
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("full_last_a", 64'(rf_write_addr), 64'(24));
        check("full_last_d", 64'(rf_write_data), 64'h224);
        check("full_drained", 64'(q_count), 64'(0));

        // Write-after-write kill
        step(1, 3, 32'h33, 1, 12, 32'd100, 12);
        check("waw_pend", 64'(query_pending), 64'(1));
        step(1, 12, 32'd999, 0, 0, 0, 12);
        check("waw_killed", 64'(query_pending), 64'(0));
        check("waw_wb_a", 64'(rf_write_addr), 64'(12));
        check("waw_wb_d", 64'(rf_write_data), 64'd999);
        check("waw_cnt", 64'(q_count), 64'(1));
        step(0, 0, 0, 0, 0, 0, 12);
        check("waw_pop_nowrite", 64'(rf_reg_write), 64'(0));
        check("waw_data_hold", 64'(rf_write_data), 64'd999);
        check("waw_empty", 64'(q_count), 64'(0));

        // Same-edge enqueue is younger than the wb write and survives
        step(1, 13, 32'd7, 1, 13, 32'd55, 13);
        check("young_pend", 64'(query_pending), 64'(1));
        check("young_wb_d", 64'(rf_write_data), 64'd7);
        step(0, 0, 0, 0, 0, 0, 13);
        check("young_w", 64'(rf_reg_write), 64'(1));
        check("young_d", 64'(rf_write_data), 64'd55);

        // Register zero
        step(1, 0, 32'h12345678, 1, 0, 32'h12345678, 0);
        check("zero_nowrite", 64'(rf_reg_write), 64'(0));
        check("zero_cnt", 64'(q_count), 64'(0));
        step(0, 0, 0, 1, 14, 32'h14, 0);
        step(1, 0, 32'h12345678, 0, 0, 0, 0);
        check("zero_slot_used", 64'(q_count), 64'(1));
        check("zero_slot_nowr", 64'(rf_reg_write), 64'(0));
        step(0, 0, 0, 0, 0, 0, 0);
        check("zero_then_a14", 64'(rf_write_addr), 64'(14));

        // Starvation of a single queued entry
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 32'(i), 1'(i == 0), 15, 32'hABC, 0);
            check("starve_stall", 64'(wb_stall), 64'(i == 9));
        end
        step(0, 0, 0, 0, 0, 0, 0);
        check("starve_pop_a", 64'(rf_write_addr), 64'(15));
        check("starve_pop_d", 64'(rf_write_data), 64'hABC);
        check("starve_clear", 64'(wb_stall), 64'(0));
        check("starve_empty", 64'(q_count), 64'(0));

        // Reset while entries are queued
        step(1, 2, 32'h22, 1, 16, 32'h16, 0);
        step(1, 2, 32'h23, 1, 17, 32'h17, 0);
        check("mid_cnt", 64'(q_count), 64'(2));
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", 64'(q_count), 64'(0));
        check("mid_rst_wr", 64'(rf_reg_write), 64'(0));
        check("mid_rst_rdy", 64'(lt_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_nowr", 64'(rf_reg_write), 64'(0));
        check("post_rst_cnt", 64'(q_count), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
